// File: rtl/iob_uart_lite_if.sv
// iob_uart_lite_if -- IOb-native CPU register port bundle for iob_uart_lite.
//   master: drives iob_avalid, iob_addr, iob_wdata, iob_wstrb; receives
//           iob_rdata, iob_rvalid, iob_ready.
//   slave : the mirror image (used by the UART).
// iob_wstrb == 0 marks a read request.
interface iob_uart_lite_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic                iob_avalid;
    logic [ADDR_W-1:0]   iob_addr;
    logic [DATA_W-1:0]   iob_wdata;
    logic [DATA_W/8-1:0] iob_wstrb;
    logic [DATA_W-1:0]   iob_rdata;
    logic                iob_rvalid;
    logic                iob_ready;

    modport master (
        output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        input  iob_rdata, iob_rvalid, iob_ready
    );

    modport slave (
        input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        output iob_rdata, iob_rvalid, iob_ready
    );
endinterface

// File: rtl/iob_uart_lite.sv
// iob_uart_lite -- memory-mapped 8N1 UART with programmable baud divider.
//   clk_i, rst_i (sync, active high), cke_i (baud/shift engine enable)
//   iob   : register port (iob_uart_lite_if.slave), ready is always 1,
//           read data returned one cycle after the request
//   txd/rxd : serial lines (txd idles high)
//   rts/cts : flow control, only when UART_RTS_CTS_EN is defined;
//             otherwise rts=1 and cts is ignored.
// Word 0: [0] W SOFTRESET / R TXREADY, [8] R RXREADY, [31:16] DIV
// Word 1: [7:0] W TXDATA / R RXDATA, [8] TXEN, [16] RXEN
module iob_uart_lite #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           cke_i,
    iob_uart_lite_if.slave iob,
    output logic           txd,
    input  logic           rxd,
    output logic           rts,
    input  logic           cts
);
    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [15:0] div;
    logic        txen, rxen, rxready;
    logic [7:0]  rxdata;
    logic        cts_ok;

    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;

    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_s1, rx_s2, rx_last, rx_done;

`ifdef UART_RTS_CTS_EN
    assign cts_ok = cts;
    assign rts    = rxen & ~rxready;
`else
    logic cts_unused;
    assign cts_unused = cts;
    assign cts_ok     = 1'b1;
    assign rts        = 1'b1;
`endif

    // Bus decode
    logic [ADDR_W-1:0] word_idx;
    logic              is_w0, is_w1, wr, rd, soft_rst, tx_load, txready;
    logic [DATA_W-1:0] rdata_n;
    logic [15:0]       div_eff, div_half;

    assign word_idx = iob.iob_addr >> 2;
    assign is_w0    = (word_idx == ADDR_W'(0));
    assign is_w1    = (word_idx == ADDR_W'(1));
    assign wr       = iob.iob_avalid & (|iob.iob_wstrb);
    assign rd       = iob.iob_avalid & ~(|iob.iob_wstrb);
    assign soft_rst = wr & is_w0 & iob.iob_wstrb[0] & iob.iob_wdata[0];
    assign txready  = (tx_state == TX_IDLE);
    assign tx_load  = wr & is_w1 & iob.iob_wstrb[0] & txen & txready;
    assign iob.iob_ready = 1'b1;

    assign div_eff  = (div < 16'd2) ? 16'd2 : div;
    assign div_half = div_eff >> 1;

    always_comb begin
        rdata_n = '0;
        if (is_w0)
            rdata_n = {div, 7'b0, rxready, 7'b0, txready};
        else if (is_w1)
            rdata_n = {8'h00, 7'b0, rxen, 7'b0, txen, rxdata};
    end

    // Transmit FSM: the IDLE/WAIT hand-off to START is a register-port
    // action and ignores cke_i; bit timing only advances on enabled cycles.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        case (tx_state)
            TX_IDLE: if (tx_load) begin
                tx_shift_n = iob.iob_wdata[7:0];
                tx_cnt_n   = '0;
                tx_state_n = cts_ok ? TX_START : TX_WAIT;
            end
            TX_WAIT: if (cts_ok) begin
                tx_cnt_n   = '0;
                tx_state_n = TX_START;
            end
            default: if (cke_i) begin
                if (tx_cnt == div_eff - 16'd1) begin
                    tx_cnt_n = '0;
                    if (tx_state == TX_START) begin
                        tx_bit_n   = '0;
                        tx_state_n = TX_DATA;
                    end else if (tx_state == TX_DATA) begin
                        tx_shift_n = tx_shift >> 1;
                        tx_bit_n   = tx_bit + 3'd1;
                        if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
        endcase
        if (soft_rst) begin
            tx_state_n = TX_IDLE;
            tx_cnt_n   = '0;
            tx_bit_n   = '0;
        end
    end

    always_comb begin
        case (tx_state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift[0];
            default:  txd = 1'b1;
        endcase
    end

    // Receive FSM: rx_last tracks the synchronized line only on enabled
    // cycles so a falling edge is never lost while the engine is frozen.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        if (cke_i) begin
            case (rx_state)
                RX_IDLE: if (rx_last & ~rx_s2) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_START;
                end
                RX_START: if (rx_cnt == div_half - 16'd1) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
                RX_DATA: if (rx_cnt == div_eff - 16'd1) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
                default: if (rx_cnt == div_eff - 16'd1) begin
                    rx_cnt_n   = '0;
                    rx_done    = rx_s2;
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            endcase
        end
        if (soft_rst || !rxen) begin
            rx_state_n = RX_IDLE;
            rx_done    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div            <= '0;
            txen           <= 1'b0;
            rxen           <= 1'b0;
            rxready        <= 1'b0;
            rxdata         <= '0;
            tx_state       <= TX_IDLE;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_shift       <= '0;
            rx_state       <= RX_IDLE;
            rx_cnt         <= '0;
            rx_bit         <= '0;
            rx_shift       <= '0;
            rx_s1          <= 1'b1;
            rx_s2          <= 1'b1;
            rx_last        <= 1'b1;
            iob.iob_rvalid <= 1'b0;
            iob.iob_rdata  <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            if (cke_i) rx_last <= rx_s2;

            iob.iob_rvalid <= rd;
            if (rd) iob.iob_rdata <= rdata_n;

            // A completing frame wins over a simultaneous read-clear.
            if (rx_done) begin
                rxdata  <= rx_shift;
                rxready <= 1'b1;
            end else if ((rd && is_w1) || soft_rst) begin
                rxready <= 1'b0;
            end

            if (wr && is_w0) begin
                if (iob.iob_wstrb[2]) div[7:0]  <= iob.iob_wdata[23:16];
                if (iob.iob_wstrb[3]) div[15:8] <= iob.iob_wdata[31:24];
            end

            if (soft_rst) begin
                txen <= 1'b0;
                rxen <= 1'b0;
            end else if (wr && is_w1) begin
                if (iob.iob_wstrb[1]) txen <= iob.iob_wdata[8];
                if (iob.iob_wstrb[2]) rxen <= iob.iob_wdata[16];
            end
        end
    end
endmodule

// File: tb/tb_iob_uart_lite.sv
// tb_iob_uart_lite -- two iob_uart_lite instances wired back to back
// (a transmits, b receives). b's rxd can be switched to a bench-driven
// line to inject hand-made frames.
module tb_iob_uart_lite;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cke, a_cts, rx_manual, b_rxd_drv;
    logic a_txd, a_rts, b_txd, b_rts, b_rxd;
    int   tests_run = 0;
    int   tests_failed = 0;

`ifdef UART_RTS_CTS_EN
    localparam logic RTS_RESET = 1'b0;
    localparam logic RTS_FULL  = 1'b0;
`else
    localparam logic RTS_RESET = 1'b1;
    localparam logic RTS_FULL  = 1'b1;
`endif

    assign b_rxd = rx_manual ? b_rxd_drv : a_txd;

    iob_uart_lite_if #(.ADDR_W(3), .DATA_W(32)) ifa ();
    iob_uart_lite_if #(.ADDR_W(3), .DATA_W(32)) ifb ();

    iob_uart_lite #(.ADDR_W(3), .DATA_W(32)) u_a (
        .clk_i(clk), .rst_i(rst), .cke_i(cke), .iob(ifa),
        .txd(a_txd), .rxd(b_txd), .rts(a_rts), .cts(a_cts)
    );

    iob_uart_lite #(.ADDR_W(3), .DATA_W(32)) u_b (
        .clk_i(clk), .rst_i(rst), .cke_i(cke), .iob(ifb),
        .txd(b_txd), .rxd(b_rxd), .rts(b_rts), .cts(a_rts)
    );

    task automatic bus_req(input int sel, input logic [2:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
        if (sel == 0) begin
            ifa.iob_avalid = 1'b1; ifa.iob_addr = addr;
            ifa.iob_wdata = data;  ifa.iob_wstrb = strb;
        end else begin
            ifb.iob_avalid = 1'b1; ifb.iob_addr = addr;
            ifb.iob_wdata = data;  ifb.iob_wstrb = strb;
        end
    endtask

    task automatic bus_idle();
        ifa.iob_avalid = 1'b0; ifa.iob_wstrb = 4'b0;
        ifb.iob_avalid = 1'b0; ifb.iob_wstrb = 4'b0;
    endtask

    task automatic bus_write(input int sel, input logic [2:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        bus_req(sel, addr, data, strb);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input int sel, input logic [2:0] addr,
                            output logic [31:0] data, output logic valid);
        @(negedge clk);
        bus_req(sel, addr, 32'h0, 4'b0);
        @(negedge clk);
        bus_idle();
        data  = (sel == 0) ? ifa.iob_rdata  : ifb.iob_rdata;
        valid = (sel == 0) ? ifa.iob_rvalid : ifb.iob_rvalid;
    endtask

    task automatic set_div(input int sel, input int d);
        bus_write(sel, 3'd0, {d[15:0], 16'h0}, 4'b1100);
    endtask

    // Samples a's txd once per cycle starting at the current negedge and
    // compares against the 8N1 waveform for byte d. Optionally injects a
    // TXDATA write (0x55) at sample inj and freezes cke for 10 cycles after
    // sample frz. Returns the first mismatching sample index or -1.
    task automatic capture_frame(input logic [7:0] d, input int divv, input int inj,
                                 input int frz, output int bad);
        int   deff, total, j, bi;
        logic expv;
        deff  = (divv < 2) ? 2 : divv;
        total = 10 * deff + ((frz >= 0) ? 10 : 0);
        bad   = -1;
        for (int i = 0; i < total; i++) begin
            if (i > 0) @(negedge clk);
            if (frz < 0 || i <= frz) j = i;
            else if (i <= frz + 10)  j = frz;
            else                     j = i - 10;
            bi = j / deff;
            if (bi == 0)      expv = 1'b0;
            else if (bi == 9) expv = 1'b1;
            else              expv = d[bi-1];
            if (a_txd !== expv && bad < 0) bad = i;
            if (i == inj) bus_req(0, 3'd4, 32'h55, 4'b0001);
            else if (i == inj + 1) bus_idle();
            if (i == frz) cke = 1'b0;
            else if (frz >= 0 && i == frz + 10) cke = 1'b1;
        end
    endtask

    task automatic wait_rx(output logic ok);
        logic [31:0] d;
        logic        v;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            bus_read(1, 3'd0, d, v);
            ok = d[8];
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      b_rxd_drv = 1'b0;
            else if (b == 9) b_rxd_drv = stop_bit;
            else             b_rxd_drv = d[b-1];
            repeat (4) @(negedge clk);
        end
        b_rxd_drv = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a_txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd got %b want 1", a_txd); end
        tests_run++;
        if (b_rts !== RTS_RESET) begin tests_failed++; $display("FAIL reset_rts got %b want %b", b_rts, RTS_RESET); end
        tests_run++;
        if (ifa.iob_rvalid !== 1'b0 || ifa.iob_rdata !== 32'h0) begin
            tests_failed++; $display("FAIL reset_rd got v=%b d=%h want 0/0", ifa.iob_rvalid, ifa.iob_rdata);
        end
        bus_read(0, 3'd0, d, v);
        tests_run++;
        if (v !== 1'b1) begin tests_failed++; $display("FAIL reset_rvalid got %b want 1", v); end
        tests_run++;
        if (d !== 32'h0000_0001) begin tests_failed++; $display("FAIL reset_word0 got %h want 00000001", d); end
        @(negedge clk);
        tests_run++;
        if (ifa.iob_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rvalid_pulse got %b want 0", ifa.iob_rvalid); end
    endtask

    task automatic test_config();
        logic [31:0] d;
        logic        v;
        set_div(0, 4);
        set_div(1, 4);
        bus_write(0, 3'd4, 32'h0000_0100, 4'b0010);
        bus_write(1, 3'd4, 32'h0001_0000, 4'b0100);
        bus_read(0, 3'd0, d, v);
        tests_run++;
        if (d !== 32'h0004_0001) begin tests_failed++; $display("FAIL cfg_a_w0 got %h want 00040001", d); end
        bus_read(0, 3'd4, d, v);
        tests_run++;
        if (d !== 32'h0000_0100) begin tests_failed++; $display("FAIL cfg_a_w1 got %h want 00000100", d); end
        bus_read(1, 3'd4, d, v);
        tests_run++;
        if (d !== 32'h0001_0000) begin tests_failed++; $display("FAIL cfg_b_w1 got %h want 00010000", d); end
        tests_run++;
        if (b_rts !== 1'b1) begin tests_failed++; $display("FAIL cfg_rts got %b want 1", b_rts); end
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        logic        v, ok;
        int          bad;
        bus_write(0, 3'd4, 32'h0000_00A5, 4'b0001);
        capture_frame(8'hA5, 4, -1, -1, bad);
        tests_run++;
        if (bad !== -1) begin tests_failed++; $display("FAIL lb_frame first bad sample %0d want none", bad); end
        wait_rx(ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL lb_rxready got %b want 1", ok); end
        tests_run++;
        if (b_rts !== RTS_FULL) begin tests_failed++; $display("FAIL lb_rts_full got %b want %b", b_rts, RTS_FULL); end
        bus_read(1, 3'd4, d, v);
        tests_run++;
        if (d !== 32'h0001_00A5) begin tests_failed++; $display("FAIL lb_rxdata got %h want 000100a5", d); end
        bus_read(1, 3'd0, d, v);
        tests_run++;
        if (d !== 32'h0004_0001) begin tests_failed++; $display("FAIL lb_rxclr got %h want 00040001", d); end
        tests_run++;
        if (b_rts !== 1'b1) begin tests_failed++; $display("FAIL lb_rts_back got %b want 1", b_rts); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [7:0]  by;
        logic        v, ok;
        int          bad, dv;
        for (int n = 0; n < 6; n++) begin
            by = 8'($urandom_range(0, 255));
            dv = $urandom_range(0, 7);
            set_div(0, dv);
            set_div(1, dv);
            bus_write(0, 3'd4, {24'h0, by}, 4'b0001);
            capture_frame(by, dv, -1, -1, bad);
            tests_run++;
            if (bad !== -1) begin tests_failed++; $display("FAIL rnd_frame byte=%h div=%0d bad sample %0d want none", by, dv, bad); end
            wait_rx(ok);
            bus_read(1, 3'd4, d, v);
            tests_run++;
            if (ok !== 1'b1 || d !== {16'h0001, 8'h00, by}) begin
                tests_failed++; $display("FAIL rnd_rx div=%0d ok=%b got %h want 000100%h", dv, ok, d, by);
            end
        end
        set_div(0, 4);
        set_div(1, 4);
    endtask

    task automatic test_cts();
        logic [31:0] d;
        logic        v, ok, stayed;
        int          bad;
        a_cts = 1'b0;
        bus_write(0, 3'd4, 32'h0000_003C, 4'b0001);
`ifdef UART_RTS_CTS_EN
        stayed = 1'b1;
        repeat (6) begin
            if (a_txd !== 1'b1) stayed = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (stayed !== 1'b1) begin tests_failed++; $display("FAIL cts_hold txd left idle, want 1"); end
        bus_write(0, 3'd4, 32'h0000_0055, 4'b0001);
        bus_read(0, 3'd0, d, v);
        tests_run++;
        if (d !== 32'h0004_0000) begin tests_failed++; $display("FAIL cts_txready got %h want 00040000", d); end
        a_cts = 1'b1;
        @(negedge clk);
`endif
        capture_frame(8'h3C, 4, 9, -1, bad);
        tests_run++;
        if (bad !== -1) begin tests_failed++; $display("FAIL cts_frame bad sample %0d want none", bad); end
        a_cts = 1'b1;
        stayed = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (a_txd !== 1'b1) stayed = 1'b0;
        end
        tests_run++;
        if (stayed !== 1'b1) begin tests_failed++; $display("FAIL busy_write_ignored second frame seen, want idle"); end
        wait_rx(ok);
        bus_read(1, 3'd4, d, v);
        tests_run++;
        if (ok !== 1'b1 || d !== 32'h0001_003C) begin tests_failed++; $display("FAIL cts_rx ok=%b got %h want 0001003c", ok, d); end
    endtask

    task automatic test_framing();
        logic [31:0] d;
        logic [7:0]  d1, d2;
        logic        v;
        @(negedge clk);
        b_rxd_drv = 1'b1;
        rx_manual = 1'b1;
        repeat (8) @(negedge clk);
        drive_frame(8'($urandom_range(0, 255)), 1'b0);
        repeat (12) @(negedge clk);
        bus_read(1, 3'd0, d, v);
        tests_run++;
        if (d !== 32'h0004_0001) begin tests_failed++; $display("FAIL frame_err got %h want 00040001", d); end
        d1 = 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        drive_frame(d1, 1'b1);
        repeat (4) @(negedge clk);
        drive_frame(d2, 1'b1);
        repeat (12) @(negedge clk);
        bus_read(1, 3'd4, d, v);
        tests_run++;
        if (d !== {16'h0001, 8'h00, d2}) begin tests_failed++; $display("FAIL overrun got %h want 000100%h", d, d2); end
        rx_manual = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_softreset();
        logic [31:0] d;
        logic        v, stayed;
        bus_write(0, 3'd4, 32'h0000_0000, 4'b0001);
        repeat (15) @(negedge clk);
        tests_run++;
        if (a_txd !== 1'b0) begin tests_failed++; $display("FAIL sr_midframe got %b want 0", a_txd); end
        bus_write(0, 3'd0, 32'h0000_0001, 4'b0001);
        tests_run++;
        if (a_txd !== 1'b1) begin tests_failed++; $display("FAIL sr_txd got %b want 1", a_txd); end
        bus_read(0, 3'd0, d, v);
        tests_run++;
        if (d !== 32'h0004_0001) begin tests_failed++; $display("FAIL sr_w0 got %h want 00040001", d); end
        bus_read(0, 3'd4, d, v);
        tests_run++;
        if (d !== 32'h0000_0000) begin tests_failed++; $display("FAIL sr_w1 got %h want 00000000", d); end
        bus_write(0, 3'd4, 32'h0000_0081, 4'b0001);
        stayed = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (a_txd !== 1'b1) stayed = 1'b0;
        end
        tests_run++;
        if (stayed !== 1'b1) begin tests_failed++; $display("FAIL txen_off_write frame started, want idle"); end
        repeat (60) @(negedge clk);
        bus_read(1, 3'd4, d, v);
        bus_write(0, 3'd4, 32'h0000_0100, 4'b0010);
    endtask

    task automatic test_cke();
        logic [31:0] d;
        logic [7:0]  by;
        logic        v, ok;
        int          bad;
        by = 8'($urandom_range(0, 255));
        bus_write(0, 3'd4, {24'h0, by}, 4'b0001);
        capture_frame(by, 4, -1, 11, bad);
        tests_run++;
        if (bad !== -1) begin tests_failed++; $display("FAIL cke_frame byte=%h bad sample %0d want none", by, bad); end
        wait_rx(ok);
        bus_read(1, 3'd4, d, v);
        tests_run++;
        if (ok !== 1'b1 || d !== {16'h0001, 8'h00, by}) begin
            tests_failed++; $display("FAIL cke_rx ok=%b got %h want 000100%h", ok, d, by);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cke = 1'b1; a_cts = 1'b1; rx_manual = 1'b0; b_rxd_drv = 1'b1;
        ifa.iob_avalid = 1'b0; ifa.iob_addr = '0; ifa.iob_wdata = '0; ifa.iob_wstrb = '0;
        ifb.iob_avalid = 1'b0; ifb.iob_addr = '0; ifb.iob_wdata = '0; ifb.iob_wstrb = '0;
        test_reset();
        test_config();
        test_loopback();
        test_random();
        test_cts();
        test_framing();
        test_softreset();
        test_cke();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/iob_uart_lite.md
# iob_uart_lite

Memory-mapped 8N1 UART peripheral with an IOb-native CPU slave port, a programmable baud divider and optional RTS/CTS flow control. Instances sit on the SoC peripheral bus, and a second instance can act as the testbench console. Two instances connect back-to-back by crossing txd/rxd and rts/cts.

## Interface
- ADDR_W, default 3: byte address width of the register port.
- DATA_W, default 32: bus data width; fixed at 32.
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- cke_i  in  1  clock enable for the baud/shift engines.
- iob_avalid_i  in  1  request valid.
- iob_addr_i  in  ADDR_W  byte address; bits [ADDR_W-1:2] select the word.
- iob_wdata_i  in  DATA_W  write data.
- iob_wstrb_i  in  DATA_W/8  byte-lane write strobes; all-zero means read.
- iob_rdata_o  out  DATA_W  read data.
- iob_rvalid_o  out  1  read data valid.
- iob_ready_o  out  1  request accepted.
- txd  out  1  serial transmit line; idle high.
- rxd  in  1  serial receive line.
- rts  out  1  ready-to-send; high means this side can accept a frame.
- cts  in  1  clear-to-send from the peer.

## Operation
Word 0, byte lanes:
- lane 0: write SOFTRESET (bit 0); read TXREADY.
- lane 1: read RXREADY.
- lanes 3:2: DIV (16-bit, R/W).

Word 1, byte lanes:
- lane 0: write TXDATA; read RXDATA.
- lane 1: TXEN (bit 0, R/W).
- lane 2: RXEN (bit 0, R/W).

Register behaviour:
- Writes update only the strobed lanes.
- Reads return the full word; unused bits read 0.
- Unmapped words read 0, and writes to them are ignored.
- SOFTRESET=1 is self-clearing. It aborts TX and RX, sets txd to 1, clears RXREADY, TXEN and RXEN, and preserves DIV.

Transmit:
- A TXDATA write is accepted only when TXEN=1 and TXREADY=1; otherwise it is ignored.
- Frame format: start bit 0, data bits [0..7] LSB first, stop bit 1. Each bit lasts DIV enabled cycles.
- The frame starts only while cts=1. If cts=0, the byte is held and TXREADY stays 0.

Receive:
- Active only while RXEN=1. rxd passes through a 2-flop synchronizer.
- A falling edge starts a frame. The start bit is re-checked at DIV/2; if it reads 1, the frame is aborted.
- Data bits are sampled at mid-bit.
- Valid stop bit (1): the byte loads into RXDATA and RXREADY is set.
- Stop bit 0: the frame is discarded.
- If a new frame completes while RXREADY=1, it overwrites RXDATA (overrun, no flag).
- A read of word 1 clears RXREADY.

Flow control:
- rts = RXEN & ~RXREADY.

## Timing
- iob_ready_o is constant 1; every request is accepted in its cycle.
- iob_rvalid_o is 1 exactly one cycle after a read request, with iob_rdata_o valid in that cycle. It is 0 otherwise, and after writes.
- Write effects are visible to a read issued in the next cycle.
- Reset values: txd=1, rts=0, iob_rvalid_o=0, iob_rdata_o=0, TXREADY=1, RXREADY=0, TXEN=0, RXEN=0, DIV=0, RXDATA=0.
- TX state machine:
  - IDLE → START on an accepted byte with cts=1, one cycle after the write.
  - START → DATA0..7 → STOP → IDLE, each state lasting DIV cycles.
  - TXREADY drops in the cycle after the write and rises when STOP ends. Frame length is 10·DIV enabled cycles.
- RX state machine: IDLE → START (check at DIV/2) → DATA0..7 (each sampled DIV cycles after the previous sample) → STOP (sampled) → IDLE. RXREADY rises one cycle after the stop sample.
- cke_i=0 freezes the baud counters and shift registers. The register port keeps working.
- DIV<2 behaves as DIV=2.
- Clearing TXEN mid-frame completes the current frame.
- Clearing RXEN mid-frame aborts RX.
- A read that clears RXREADY in the same cycle a new frame completes leaves RXREADY=1 with the new data.
- rst_i mid-frame returns all state to reset values in the next cycle.

## Configuration
- UART_RTS_CTS_EN defined: flow control as above.
- Not defined: rts is tied to 1 and cts is ignored (treated as 1).

## Test plan
- Reset: after rst_i, read word 0 → 0x0000_0001. txd=1, rts=0, iob_rvalid_o pulses one cycle after the read.
- Loopback pair at DIV=4: TX side sends TXDATA=0xA5. txd shows 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles. The RX side gets RXREADY=1 and RXDATA=0xA5 about 40 cycles later.
- Read of word 1 after reception returns byte 0xA5 in lane 0. A subsequent word-0 read shows RXREADY=0, and rts returns to 1.
- With cts=0, write 0x3C: txd stays 1 and TXREADY stays 0. Raise cts → the frame starts the next cycle. A second write while busy is ignored.
- Framing error: drive a frame with stop bit 0 → RXREADY stays 0. Write SOFTRESET mid-TX → txd=1 next cycle, TXEN=0, DIV unchanged.
- cke_i held low for 10 cycles mid-frame → the frame is stretched by exactly 10 cycles, and the data is still received correctly.
